// File: rtl/aes_pkg.sv
// AES helpers shared by the InvMixColumns datapath.
//   - AES_COLS: number of 32-bit columns in a 128-bit state
//   - imc_state_e: control states of the iterative InvMixColumns block
//   - xtime / gf_mul9 / gf_mulb / gf_muld / gf_mule: GF(2^8) constant multiplies, poly 0x11B
//   - get_col: column c of a 128-bit state (column 0 is bits [31:0])
package aes_pkg;

    localparam int unsigned AES_COLS = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } imc_state_e;

    // Multiply by x (0x02), reducing by 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
        return s[{c, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/inv_mixcolumn.sv
// One-column AES InvMixColumns, purely combinational.
//   col_i : input column, row 0 in bits [7:0]
//   col_o : column multiplied by the circulant {0e,0b,0d,09}
module inv_mixcolumn
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_i[7:0];
    assign a1 = col_i[15:8];
    assign a2 = col_i[23:16];
    assign a3 = col_i[31:24];

    assign col_o[7:0]   = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
    assign col_o[15:8]  = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
    assign col_o[23:16] = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
    assign col_o[31:24] = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);

endmodule

// File: rtl/inv_mixcolumns.sv
// Iterative AES InvMixColumns with valid/ready handshakes on both sides.
// A captured state is transformed in place, COLS_PER_CYCLE columns per clock, and then
// held until the downstream accepts it.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : state_in valid          in_ready  : block is idle and can accept a state
//   state_in  : 128-bit input state
//   out_valid : state_out is final      out_ready : downstream accepts state_out
//   state_out : work register (partial values while computing)
module inv_mixcolumns
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
        $error("inv_mixcolumns: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    imc_state_e   state_q, state_d;
    logic [1:0]   col_idx_q, col_idx_d;
    logic [127:0] work_q, work_d;
    logic         last_group;

    logic [1:0]  col_sel [COLS_PER_CYCLE];
    logic [31:0] col_in  [COLS_PER_CYCLE];
    logic [31:0] col_out [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        // 2-bit add wraps harmlessly: with 4 columns per cycle col_idx stays 0.
        assign col_sel[g] = col_idx_q + 2'(g);
        assign col_in[g]  = get_col(work_q, col_sel[g]);

        inv_mixcolumn u_col (
            .col_i (col_in[g]),
            .col_o (col_out[g])
        );
    end

    // Exit is decoded on the final group so col_idx never needs to count past 3.
    assign last_group = (col_idx_q == 2'(AES_COLS - COLS_PER_CYCLE));

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        work_d    = work_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d    = state_in;
                    col_idx_d = 2'd0;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
                    for (int c = 0; c < int'(AES_COLS); c++) begin
                        if (col_sel[g] == 2'(c)) begin
                            work_d[32*c +: 32] = col_out[g];
                        end
                    end
                end
                col_idx_d = col_idx_q + 2'(COLS_PER_CYCLE);
                if (last_group) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            col_idx_q <= 2'd0;
            work_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            work_q    <= work_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign state_out = work_q;

endmodule

// File: tb/tb_inv_mixcolumns.sv
// Directed and round-trip checks for inv_mixcolumns; extra instances cover the 2- and
// 4-column-per-cycle latencies.
module tb_inv_mixcolumns;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    logic         in_valid_p2, in_ready_p2, out_valid_p2;
    logic [127:0] state_out_p2;
    logic         in_valid_p4, in_ready_p4, out_valid_p4;
    logic [127:0] state_out_p4;

    int n_total;
    int n_bad;

    localparam logic [127:0] FipsIn   = {4{32'hbca14d8e}};
    localparam logic [127:0] FipsOut  = {4{32'h455313db}};
    localparam logic [127:0] MixedIn  = {32'hc6c6c6c6, 32'hf8bd7e4d, 32'hd6d7d5d5, 32'h9d58dc9f};
    localparam logic [127:0] MixedOut = {32'hc6c6c6c6, 32'h4c31262d, 32'hd5d4d4d4, 32'h5c220af2};

    inv_mixcolumns #(.COLS_PER_CYCLE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    inv_mixcolumns #(.COLS_PER_CYCLE(2)) dut_p2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_p2),
        .in_ready  (in_ready_p2),
        .state_in  (state_in),
        .out_valid (out_valid_p2),
        .out_ready (out_ready),
        .state_out (state_out_p2)
    );

    inv_mixcolumns #(.COLS_PER_CYCLE(4)) dut_p4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_p4),
        .in_ready  (in_ready_p4),
        .state_in  (state_in),
        .out_valid (out_valid_p4),
        .out_ready (out_ready),
        .state_out (state_out_p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, need finish");
        $fatal(1, "watchdog");
    end

    // Forward MixColumns model, used to build round-trip stimulus.
    function automatic logic [7:0] tb_xt(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        a0 = w[7:0];
        a1 = w[15:8];
        a2 = w[23:16];
        a3 = w[31:24];
        b0 = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
        b3 = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            r[32*c +: 32] = fwd_col(s[32*c +: 32]);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one state through the main instance; report result and accept-to-valid cycles.
    task automatic do_xfer(input logic [127:0] s, output logic [127:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        state_in = s;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        res = state_out;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_total++;
        if (out_valid !== 1'b0 || state_out !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_hold: out_valid=%b state_out=%h, need 0 and 0",
                     out_valid, state_out);
        end
        #3;
        rst = 1'b0;
        step();
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || state_out !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b state_out=%h, need 1 0 0",
                     in_ready, out_valid, state_out);
        end
    endtask

    task automatic test_fips();
        logic [127:0] res;
        int lat;
        do_xfer(FipsIn, res, lat);
        n_total++;
        if (res !== FipsOut) begin
            n_bad++;
            $display("FAIL fips: got %h need %h", res, FipsOut);
        end
        n_total++;
        if (lat !== 4) begin
            n_bad++;
            $display("FAIL fips_latency: got %0d need 4", lat);
        end
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL fips_after: in_ready=%b out_valid=%b need 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_mixed();
        logic [127:0] res;
        int lat;
        do_xfer(MixedIn, res, lat);
        n_total++;
        if (res !== MixedOut) begin
            n_bad++;
            $display("FAIL mixed: got %h need %h", res, MixedOut);
        end
        n_total++;
        if (lat !== 4) begin
            n_bad++;
            $display("FAIL mixed_latency: got %0d need 4", lat);
        end
    endtask

    task automatic test_latency_wide();
        int lat2, lat4;
        lat2 = -1;
        lat4 = -1;
        n_total++;
        if (in_ready_p2 !== 1'b1 || in_ready_p4 !== 1'b1) begin
            n_bad++;
            $display("FAIL wide_idle: in_ready_p2=%b in_ready_p4=%b need 1 1",
                     in_ready_p2, in_ready_p4);
        end
        state_in = MixedIn;
        in_valid_p2 = 1'b1;
        in_valid_p4 = 1'b1;
        step();
        in_valid_p2 = 1'b0;
        in_valid_p4 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (out_valid_p2 && lat2 < 0) lat2 = k;
            if (out_valid_p4 && lat4 < 0) lat4 = k;
        end
        n_total++;
        if (lat2 !== 2) begin
            n_bad++;
            $display("FAIL latency_p2: got %0d need 2", lat2);
        end
        n_total++;
        if (lat4 !== 1) begin
            n_bad++;
            $display("FAIL latency_p4: got %0d need 1", lat4);
        end
        n_total++;
        if (state_out_p2 !== MixedOut) begin
            n_bad++;
            $display("FAIL mixed_p2: got %h need %h", state_out_p2, MixedOut);
        end
        n_total++;
        if (state_out_p4 !== MixedOut) begin
            n_bad++;
            $display("FAIL mixed_p4: got %h need %h", state_out_p4, MixedOut);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_total++;
        if (out_valid_p2 !== 1'b0 || out_valid_p4 !== 1'b0 || in_ready_p2 !== 1'b1 ||
            in_ready_p4 !== 1'b1) begin
            n_bad++;
            $display("FAIL wide_release: ov2=%b ov4=%b ir2=%b ir4=%b need 0 0 1 1",
                     out_valid_p2, out_valid_p4, in_ready_p2, in_ready_p4);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] orig, res;
        int lat;
        for (int k = 0; k < 1002; k++) begin
            if (k == 0) orig = 128'h0;
            else if (k == 1) orig = {16{8'h01}};
            else orig = {$urandom, $urandom, $urandom, $urandom};
            do_xfer(fwd_mix(orig), res, lat);
            n_total++;
            if (res !== orig) begin
                n_bad++;
                $display("FAIL round_trip[%0d]: got %h need %h", k, res, orig);
            end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        state_in = MixedIn;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            step();
            guard++;
        end
        for (int k = 0; k < 20; k++) begin
            state_in = FipsIn;
            in_valid = 1'b1;
            n_total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== MixedOut) begin
                n_bad++;
                $display("FAIL hold[%0d]: out_valid=%b in_ready=%b state_out=%h need 1 0 %h",
                         k, out_valid, in_ready, state_out, MixedOut);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b need 0 1", out_valid, in_ready);
        end
        guard = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (out_valid !== 1'b0) guard++;
        end
        n_total++;
        if (guard !== 0) begin
            n_bad++;
            $display("FAIL bp_ignored: out_valid high %0d cycles, need 0", guard);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] res;
        int lat, spurious;
        state_in = FipsIn;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || state_out !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_mid: out_valid=%b state_out=%h need 0 0", out_valid, state_out);
        end
        #3;
        rst = 1'b0;
        step();
        spurious = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid !== 1'b0) spurious++;
            step();
        end
        n_total++;
        if (spurious !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_output: out_valid high %0d cycles, need 0", spurious);
        end
        do_xfer(MixedIn, res, lat);
        n_total++;
        if (res !== MixedOut || lat !== 4) begin
            n_bad++;
            $display("FAIL reset_mid_next: got %h lat %0d need %h lat 4", res, lat, MixedOut);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vec [4];
        logic [127:0] exp [4];
        logic [127:0] got [4];
        int t [4];
        int n_in, n_out, cyc;
        logic acc;
        vec[0] = FipsIn;
        exp[0] = FipsOut;
        vec[1] = MixedIn;
        exp[1] = MixedOut;
        vec[2] = fwd_mix(128'h0123456789abcdeffedcba9876543210);
        exp[2] = 128'h0123456789abcdeffedcba9876543210;
        vec[3] = {16{8'h01}};
        exp[3] = {16{8'h01}};
        for (int k = 0; k < 4; k++) begin
            got[k] = '0;
            t[k] = 0;
        end
        n_in = 0;
        n_out = 0;
        cyc = 0;
        state_in = vec[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (n_out < 4 && cyc < 200) begin
            acc = in_ready && in_valid;
            if (out_valid) begin
                got[n_out] = state_out;
                t[n_out] = cyc;
                n_out++;
            end
            step();
            cyc++;
            if (acc) begin
                n_in++;
                if (n_in < 4) state_in = vec[n_in];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_total++;
        if (n_out !== 4) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d results need 4", n_out);
        end
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (got[k] !== exp[k]) begin
                n_bad++;
                $display("FAIL b2b_data[%0d]: got %h need %h", k, got[k], exp[k]);
            end
        end
        for (int k = 1; k < 4; k++) begin
            n_total++;
            if (t[k] - t[k-1] !== 6) begin
                n_bad++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles need 6", k, t[k] - t[k-1]);
            end
        end
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_valid_p2 = 1'b0;
        in_valid_p4 = 1'b0;
        out_ready = 1'b0;
        state_in = '0;
        test_reset();
        test_fips();
        test_mixed();
        test_latency_wide();
        test_round_trip();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
